// File: rtl/fifo_push_wr_pkg.sv
// Shared constants, AW entry layout and FSM states
// for the write-request push/pop FIFO pair.
package fifo_push_wr_pkg;

  localparam int ID_WIDTH      = 4;
  localparam int ADDR_WIDTH    = 64;
  localparam int LEN_WIDTH     = 8;
  localparam int AxSIZE_WIDTH  = 3;
  localparam int AxBURST_WIDTH = 2;
  localparam int AWUSER_WIDTH  = 2;

  localparam int DATA_WIDTH    = 1024;
  localparam int WSTRB_WIDTH   = DATA_WIDTH / 8;

  // AW entry bit offsets, LSB first: burst, user, size, len, addr, id
  localparam int AW_BURST_LSB  = 0;
  localparam int AW_USER_LSB   = AW_BURST_LSB + AxBURST_WIDTH;
  localparam int AW_SIZE_LSB   = AW_USER_LSB + AWUSER_WIDTH;
  localparam int AW_LEN_LSB    = AW_SIZE_LSB + AxSIZE_WIDTH;
  localparam int AW_ADDR_LSB   = AW_LEN_LSB + LEN_WIDTH;
  localparam int AW_ID_LSB     = AW_ADDR_LSB + ADDR_WIDTH;
  localparam int AW_ENTRY_W    = AW_ID_LSB + ID_WIDTH;

  // W entry: {WDATA, WSTRB}
  localparam int W_STRB_LSB    = 0;
  localparam int W_DATA_LSB    = WSTRB_WIDTH;
  localparam int W_ENTRY_W     = DATA_WIDTH + WSTRB_WIDTH;

  typedef enum logic {
    WR_IDLE,
    WR_DATA
  } request_push_fsm_wr_state;

  // Field order matches the offsets above (MSB first)
  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [LEN_WIDTH-1:0]     len;
    logic [AxSIZE_WIDTH-1:0]  size;
    logic [AWUSER_WIDTH-1:0]  user;
    logic [AxBURST_WIDTH-1:0] burst;
  } aw_entry_t;

endpackage

// File: rtl/fifo_push_wr_if.sv
// AXI4 AW + W channel bundle between an AXI master
// and the write-request push stage.
interface fifo_push_wr_if;
  import fifo_push_wr_pkg::*;

  logic                     AWVALID;
  logic                     AWREADY;
  logic [ID_WIDTH-1:0]      AWID;
  logic [ADDR_WIDTH-1:0]    AWADDR;
  logic [LEN_WIDTH-1:0]     AWLEN;
  logic [AxSIZE_WIDTH-1:0]  AWSIZE;
  logic [AxBURST_WIDTH-1:0] AWBURST;
  logic [AWUSER_WIDTH-1:0]  AWUSER;

  logic                     WVALID;
  logic                     WREADY;
  logic [DATA_WIDTH-1:0]    WDATA;
  logic [WSTRB_WIDTH-1:0]   WSTRB;
  logic                     WLAST;

  modport master (
    output AWVALID, AWID, AWADDR, AWLEN,
    output AWSIZE, AWBURST, AWUSER,
    output WVALID, WDATA, WSTRB, WLAST,
    input  AWREADY, WREADY
  );

  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN,
    input  AWSIZE, AWBURST, AWUSER,
    input  WVALID, WDATA, WSTRB, WLAST,
    output AWREADY, WREADY
  );

endinterface

// File: rtl/fifo_push_wr.sv
// AXI write ingress: holds AW, streams W beats into the
// W FIFO, commits AW only once its last beat is pushed.
module fifo_push_wr
  import fifo_push_wr_pkg::*;
(
  input  logic                  CLK,
  input  logic                  ARST,
  fifo_push_wr_if.slave         axi,
  input  logic                  aw_fifo_full,
  output logic                  aw_fifo_wr_en,
  output logic [AW_ENTRY_W-1:0] aw_fifo_wr_data,
  input  logic                  w_fifo_full,
  output logic                  w_fifo_wr_en,
  output logic [W_ENTRY_W-1:0]  w_fifo_wr_data,
  output logic                  wlast_err
);

  request_push_fsm_wr_state state_q, state_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  aw_entry_t            hold_q, hold_d;
  logic                 err_q, err_d;

  logic aw_ready;
  logic w_ready;
  logic aw_push;
  logic w_push;

  // State, beat counter, AW holding register, error flag
  always_ff @(posedge CLK) begin
    if (ARST) begin
      state_q <= WR_IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Handshakes, pushes and next-state; AWLEN decides the
  // last beat, WLAST only feeds the mismatch flag
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    hold_d   = hold_q;
    err_d    = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    aw_push  = 1'b0;
    w_push   = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        aw_ready = !aw_fifo_full;
        if (axi.AWVALID && aw_ready) begin
          hold_d.id    = axi.AWID;
          hold_d.addr  = axi.AWADDR;
          hold_d.len   = axi.AWLEN;
          hold_d.size  = axi.AWSIZE;
          hold_d.user  = axi.AWUSER;
          hold_d.burst = axi.AWBURST;
          beat_d       = axi.AWLEN;
          state_d      = WR_DATA;
        end
      end
      WR_DATA: begin
        w_ready = !w_fifo_full;
        if (axi.WVALID && w_ready) begin
          w_push = 1'b1;
          if (beat_q != '0) begin
            beat_d = beat_q - LEN_WIDTH'(1);
            err_d  = axi.WLAST;
          end else begin
            aw_push = 1'b1;
            err_d   = !axi.WLAST;
            state_d = WR_IDLE;
          end
        end
      end
    endcase
  end

  assign axi.AWREADY     = aw_ready & !ARST;
  assign axi.WREADY      = w_ready & !ARST;
  assign aw_fifo_wr_en   = aw_push & !ARST;
  assign w_fifo_wr_en    = w_push & !ARST;
  assign wlast_err       = err_q & !ARST;
  assign aw_fifo_wr_data = ARST ? '0 : hold_q;
  assign w_fifo_wr_data  = ARST ? '0
                         : {axi.WDATA, axi.WSTRB};

endmodule

// File: doc/fifo_push_wr.md
Name: fifo_push_wr

Overview:
- AXI4 slave write-channel ingress for the TL_TX request path.
- Accepts AW and W channel handshakes from the AXI master and packs address/control and data beats into the AW FIFO and W FIFO.
- The AW entry is committed only after the last W beat of its burst is pushed, so the downstream pop FSM never sees an AW entry without its complete data.
- Checks WLAST against AWLEN and flags mismatches.

Parameters:
- ID_WIDTH, 4, AWID/entry ID width
- ADDR_WIDTH, 64, AWADDR width
- LEN_WIDTH, 8, AWLEN width (= $clog2(AXI_MAX_NUM_TRANSFERS))
- AxSIZE_WIDTH, 3, AWSIZE width
- AxBURST_WIDTH, 2, AWBURST width
- AWUSER_WIDTH, 2, AWUSER width; [1:0]=2'b01 marks posted
- DATA_WIDTH, 1024, WDATA width (AXI_MAX_NUM_BYTES*8)
- WSTRB_WIDTH, DATA_WIDTH/8, WSTRB width

Ports:
- CLK  in  1  clock
- ARST  in  1  synchronous active-high reset
- AWVALID  in  1  AXI AW valid
- AWREADY  out  1  AXI AW ready
- AWID  in  ID_WIDTH
- AWADDR  in  ADDR_WIDTH
- AWLEN  in  LEN_WIDTH
- AWSIZE  in  AxSIZE_WIDTH
- AWBURST  in  AxBURST_WIDTH
- AWUSER  in  AWUSER_WIDTH
- WVALID  in  1  AXI W valid
- WREADY  out  1  AXI W ready
- WDATA  in  DATA_WIDTH
- WSTRB  in  WSTRB_WIDTH
- WLAST  in  1
- aw_fifo_full  in  1  AW FIFO full
- aw_fifo_wr_en  out  1  AW FIFO push
- aw_fifo_wr_data  out  ID+ADDR+LEN+SIZE+BURST+USER  packed AW entry, MSB to LSB: {ID, ADDR, LEN, SIZE, USER, BURST}
- w_fifo_full  in  1  W FIFO full
- w_fifo_wr_en  out  1  W FIFO push
- w_fifo_wr_data  out  DATA_WIDTH+WSTRB_WIDTH  {WDATA, WSTRB}
- wlast_err  out  1  one-cycle pulse on WLAST/AWLEN mismatch

Behaviour:
- Reset: ARST high at a CLK edge forces state=WR_IDLE, beat_cnt=0, AW holding register=0, wlast_err=0.
  - All outputs are 0 while ARST is high.
  - Reset mid-burst discards the held AW and un-committed beats already in the W FIFO; the FIFO owner resets the FIFO on the same ARST.
- FSM state WR_IDLE:
  - AWREADY = !aw_fifo_full; WREADY = 0.
  - On AWVALID&&AWREADY: capture all AW fields into the holding register, set beat_cnt=AWLEN, go to WR_DATA.
- FSM state WR_DATA:
  - AWREADY = 0; WREADY = !w_fifo_full.
  - On WVALID&&WREADY: w_fifo_wr_en=1 and w_fifo_wr_data={WDATA,WSTRB}, same cycle, combinational.
  - If beat_cnt!=0: decrement beat_cnt. If WLAST=1, pulse wlast_err next cycle.
  - If beat_cnt==0: aw_fifo_wr_en=1 in the same cycle with the packed holding register, then go to WR_IDLE. If WLAST=0, pulse wlast_err next cycle.
  - AWLEN is authoritative; WLAST never terminates a burst early.
- AW FIFO space: AWREADY is granted only when the AW FIFO is not full. This block is the only pusher, so that space persists until commit; no full check is needed at commit time.
- W FIFO full mid-burst: WREADY=0 stalls the burst indefinitely; no beat is lost or duplicated.
- The W FIFO depth must be >= AXI_MAX_NUM_TRANSFERS (integration requirement).
- Throughput: one AW per burst; one idle cycle between bursts (the return to WR_IDLE); one beat per cycle otherwise.
- A W beat presented while in WR_IDLE is not accepted (WREADY=0).
- Widths: beat_cnt is LEN_WIDTH bits; decrement never underflows.
- AWREADY, WREADY, aw_fifo_wr_en and w_fifo_wr_en are combinational from state and FIFO-full inputs. wlast_err is registered.

Decomposition:
- Add to axi_slave_package:
  - typedef enum request_push_fsm_wr_state {wr_push_Idle, W_Push}.
  - Field-offset localparams for the AW entry, shared with fifo_pop_wr so pack and unpack stay consistent.
  - DATA/STRB width constants.
- No sub-module. The holding register and counter are inline.

Test Plan:
- AWLEN=0, AWID=4'h3, AWADDR=64'h1000; one W beat with WLAST=1 -> one w_fifo_wr_en; aw_fifo_wr_en in the same cycle; entry ID field=3, ADDR=64'h1000; AWREADY returns 1 a cycle later.
- AWLEN=3; 4 beats, WVALID constant -> 4 consecutive W pushes; a single AW push coincident with the 4th; wlast_err never asserts.
- AWLEN=3; w_fifo_full asserted for 5 cycles after beat 2 -> WREADY=0 for those 5 cycles; beats 3-4 pushed after release; AW pushed with beat 4.
- AWLEN=2 with WLAST on beat 1 -> wlast_err pulses one cycle after beat 1; 3 beats still accepted; AW pushed on beat 3.
- aw_fifo_full=1 with AWVALID=1 -> AWREADY=0, no capture; deassert full -> handshake next cycle.
- ARST during WR_DATA after 2 of 4 beats -> next cycle state idle, all outputs 0, no AW push.
